// File: rtl/nibble_serial_add_sequencer_pkg.sv
// Shared definitions for the nibble-serial add/subtract sequencer:
// nibble width and the sequencer state encoding.
package nibble_serial_add_sequencer_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_add_sequencer_cla.sv
// Purely combinational 4-bit carry-look-ahead adder used once per nibble step.
module cla_nibble_adder
    import nibble_serial_add_sequencer_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W-1:0] g;
    logic [NIBBLE_W-1:0] p;
    logic [NIBBLE_W-1:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is flattened to generate/propagate terms of the nibble inputs.
    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign sum = p ^ c;

endmodule

// File: rtl/nibble_serial_add_sequencer.sv
// Serial add/subtract engine: one 4-bit CLA step per cycle over WIDTH/4 nibbles,
// with a valid/ready request side and a valid/ready result side.
module nibble_serial_add_sequencer
    import nibble_serial_add_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / NIBBLE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    logic [NIBBLE_W-1:0] nib_a;
    logic [NIBBLE_W-1:0] nib_b;
    logic [NIBBLE_W-1:0] nib_sum;
    logic                nib_cout;

    assign nib_a = a_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];
    assign nib_b = b_q[int'(idx_q) * NIBBLE_W +: NIBBLE_W];

    cla_nibble_adder u_cla (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry_q),
        .sum  (nib_sum),
        .cout (nib_cout)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is folded into addition of ~b with carry-in 1.
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[int'(idx_q) * NIBBLE_W +: NIBBLE_W] = nib_sum;
                carry_d = nib_cout;
                if (idx_q == LAST_IDX) begin
                    // Carry into the MSB is recovered from the top nibble's sum bit.
                    idx_d   = '0;
                    cout_d  = nib_cout;
                    ovf_d   = nib_cout ^ (nib_sum[NIBBLE_W-1] ^ nib_a[NIBBLE_W-1] ^ nib_b[NIBBLE_W-1]);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = RUN;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            idx_q   <= idx_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_sequencer.sv
// Scoreboard bench for the nibble-serial adder: randomized and directed operations
// checked against an arithmetic reference model, with stall and reset scenarios.
module tb_nibble_serial_add_sequencer;

    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    nibble_serial_add_sequencer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ov;
        int           acc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_err;
    int   cyc;
    int   rdy_mode;
    logic rdy_force;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic and the sign rule for overflow.
    function automatic exp_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic s, input logic ci);
        exp_t       e;
        logic [W:0] full;
        if (s) begin
            e.s  = x - y;
            e.co = (x >= y);
            e.ov = (x[W-1] != y[W-1]) && (e.s[W-1] != x[W-1]);
        end else begin
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            e.s  = full[W-1:0];
            e.co = full[W];
            e.ov = (x[W-1] == y[W-1]) && (e.s[W-1] != x[W-1]);
        end
        e.acc = 0;
        return e;
    endfunction

    // Result side handshake: fixed high, random, or forced by the main sequence.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0: out_ready = 1'b1;
                1: out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = rdy_force;
            endcase
        end
    end

    // Monitor: checks every DONE cycle against the head of the scoreboard.
    logic seen;
    logic prev_stall;
    int   first_cyc;
    initial begin
        seen = 1'b0;
        prev_stall = 1'b0;
        first_cyc = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                seen = 1'b0;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) check("stall_valid_held", 64'(out_valid), 64'd1);
                if (out_valid) begin
                    if (!seen) begin
                        seen = 1'b1;
                        first_cyc = cyc;
                    end
                    check("in_ready_in_done", 64'(in_ready), 64'd0);
                    if (sb.size() == 0) begin
                        check("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        check("result", {46'd0, sum, cout, ovf}, {46'd0, sb[0].s, sb[0].co, sb[0].ov});
                        if (out_ready) begin
                            check("latency", 64'(first_cyc - sb[0].acc), 64'(N));
                            void'(sb.pop_front());
                            seen = 1'b0;
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
            end
        end
    end

    task automatic present(input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic s, input logic ci);
        @(posedge clk);
        #1;
        a = x;
        b = y;
        sub = s;
        cin = ci;
        in_valid = 1'b1;
    endtask

    task automatic wait_accept(input exp_t e);
        int   t;
        logic ok;
        exp_t ee;
        t = 0;
        ok = 1'b0;
        while (!ok && t < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else t++;
        end
        if (!ok) begin
            check("accept_timeout", 64'd1, 64'd0);
            in_valid = 1'b0;
        end else begin
            ee = e;
            ee.acc = cyc + 1;
            sb.push_back(ee);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            sub = 1'($urandom);
            cin = 1'($urandom);
        end
    endtask

    task automatic do_op_exp(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                             input logic ci, input logic [W-1:0] es, input logic eco,
                             input logic eov);
        exp_t e;
        e.s = es;
        e.co = eco;
        e.ov = eov;
        e.acc = 0;
        present(x, y, s, ci);
        wait_accept(e);
    endtask

    task automatic do_op_rand();
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         s;
        logic         ci;
        x = W'($urandom);
        y = W'($urandom);
        case ($urandom_range(0, 3))
            0: x = {1'b0, {(W-1){1'b1}}};
            1: y = {1'b1, {(W-1){1'b0}}};
            default: ;
        endcase
        s = 1'($urandom);
        ci = 1'($urandom);
        present(x, y, s, ci);
        wait_accept(ref_model(x, y, s, ci));
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int t;
        n_cmp = 0;
        n_err = 0;
        cyc = 0;
        rdy_mode = 0;
        rdy_force = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        sub = 1'b0;
        cin = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_outputs", {46'd0, sum, cout, ovf}, 64'd0);
        rst_n = 1'b1;

        do_op_exp(16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
        do_op_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op_exp(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        do_op_exp(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        do_op_exp(16'h0005, 16'h0003, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0);
        drain();

        // Stall in DONE while a new request waits on the input side.
        rdy_force = 1'b0;
        rdy_mode = 2;
        do_op_exp(16'h00F0, 16'h0F10, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", 64'(out_valid), 64'd1);
        present(16'hAAAA, 16'h5555, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("stall_no_accept", 64'(in_ready), 64'd0);
        end
        rdy_force = 1'b1;
        wait_accept(ref_model(16'hAAAA, 16'h5555, 1'b0, 1'b1));
        drain();
        rdy_mode = 0;

        // Reset in the middle of RUN throws the operation away.
        do_op_exp(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrun_rst_out_valid", 64'(out_valid), 64'd0);
        check("midrun_rst_in_ready", 64'(in_ready), 64'd1);
        check("midrun_rst_outputs", {46'd0, sum, cout, ovf}, 64'd0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        do_op_exp(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);
        drain();

        rdy_mode = 1;
        for (int i = 0; i < 60; i++) begin
            do_op_rand();
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/nibble_serial_add_sequencer.md
NIBBLE_SERIAL_ADD_SEQUENCER -- requirements
Module: nibble_serial_add_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand width in bits; SHALL be a multiple of 4 and at least 4.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  request carries a valid operand set.
REQ-005 in_ready  out  1  block can accept a request.
REQ-006 a  in  WIDTH  operand A.
REQ-007 b  in  WIDTH  operand B.
REQ-008 sub  in  1  1 = compute A-B, 0 = compute A+B+cin.
REQ-009 cin  in  1  carry-in for add; ignored when sub=1.
REQ-010 out_valid  out  1  result available.
REQ-011 out_ready  in  1  consumer takes result.
REQ-012 sum  out  WIDTH  result.
REQ-013 cout  out  1  final carry-out (sub: 1 = no borrow).
REQ-014 ovf  out  1  two's-complement signed overflow.

Function
REQ-015 The block SHALL use one FSM with states IDLE, RUN and DONE; N = WIDTH/4 nibble steps per operation.
REQ-016 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE; both are registered or state-decoded, never combinational from inputs.
REQ-017 Accept = in_valid & in_ready: latch A, B' = sub ? ~b : b, carry = sub ? 1 : cin, nibble index 0, sub flag; IDLE -> RUN.
REQ-018 Each RUN cycle: adder gets A[4i+3:4i], B'[4i+3:4i], carry reg; nibble sum written to sum[4i+3:4i]; carry reg <= nibble carry-out; index i increments.
REQ-019 After the RUN cycle with i = N-1: RUN -> DONE; cout = final carry; ovf = carry into bit WIDTH-1 XOR cout.
REQ-020 Latency: accept at edge k -> out_valid high after edge k+N; WIDTH=4 gives one RUN cycle.
REQ-021 DONE: sum, cout, ovf held stable while out_valid=1 & out_ready=0; out_valid & out_ready -> IDLE at next edge.
REQ-022 No accept in the handshake cycle leaving DONE; a request held on in_valid is accepted no earlier than the following IDLE cycle.
REQ-023 a, b, sub, cin SHALL be sampled only at accept; changes during RUN/DONE have no effect.
REQ-024 Index counter SHALL be ceil(log2(N)) bits min 1, and SHALL NOT wrap past N-1 in RUN.
REQ-025 out_ready while not in DONE SHALL be ignored.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, cout=0, ovf=0, carry reg=0, index=0.
REQ-027 Reset during RUN or DONE SHALL discard the operation; no partial result is presented.
REQ-028 After rst_n deassert, the first rising edge with in_valid=1 SHALL accept.

Structure
REQ-029 Shared package SHALL hold NIBBLE_W=4 and the FSM state enum (IDLE, RUN, DONE).
REQ-030 One sub-module SHALL be instantiated: cla_nibble_adder, a purely combinational 4-bit carry-look-ahead adder (a, b, cin -> sum, cout); the sequencer owns all registers.

Verification (WIDTH=16)
REQ-031 a=0x1234, b=0x0FFF, sub=0, cin=0 -> sum=0x2233, cout=0, ovf=0, out_valid exactly 4 cycles after accept.
REQ-032 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 4 steps).
REQ-033 a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1; a=0x8000, b=0x8000 -> sum=0x0000, cout=1, ovf=1.
REQ-034 sub=1, a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0; sub=1, a=0x0005, b=0x0003 -> sum=0x0002, cout=1.
REQ-035 out_ready low 3 cycles in DONE with in_valid=1 and new operands -> sum/cout/ovf unchanged, in_ready=0, no second accept; out_ready=1 -> IDLE, then second request accepted.
REQ-036 rst_n pulsed low during RUN step 2 -> out_valid=0 and in_ready=1 without clock edge; next operation 0x0001+0x0001 -> sum=0x0002.
